fixedpt_butterfly: RTL
======================

FIXEDPT_BUTTERFLY -- requirements
Module: fixedpt_butterfly

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning total bit width of every real/imaginary word.
REQ-002 The block SHALL have parameter d, default 16, meaning number of fractional bits (Q(n-d).d, two's complement).
REQ-003 The block SHALL have parameter scale, default 0, meaning 1 = halve both outputs per stage (FFT growth control), 0 = no scaling.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on posedge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port recv_val  input  1  upstream operands valid.
REQ-007 The block SHALL have port recv_rdy  output  1  block can accept an operand set.
REQ-008 The block SHALL have ports ar, ac  input  n  real/imag of butterfly top input a.
REQ-009 The block SHALL have ports pr, pc  input  n  real/imag of twiddled product p = w*b, supplied by the upstream complex multiplier.
REQ-010 The block SHALL have port send_val  output  1  result valid.
REQ-011 The block SHALL have port send_rdy  input  1  downstream ready.
REQ-012 The block SHALL have ports c0r, c0c  output  n  result a + p.
REQ-013 The block SHALL have ports c1r, c1c  output  n  result a - p.
REQ-014 The block SHALL have port clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-015 The block SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-016 The block SHALL accept an operand set on any posedge where recv_val & recv_rdy are both high.
REQ-017 The block SHALL compute the four sums (ar±pr, ac±pc) at n+1 bits, sign-extended.
REQ-018 When scale=0, the block SHALL produce outputs as the low n bits of each sum (wrap).
REQ-019 When scale=1, the block SHALL produce outputs as bits [n:1] of each sum (arithmetic shift right by 1, truncation toward -inf).
REQ-020 When scale=0, the block SHALL set ovf on acceptance if bit n differs from bit n-1 in any of the four sums; when scale=1, ovf SHALL never set.
REQ-021 ovf SHALL stay high until reset or clr_ovf; if clr_ovf and a new overflow occur in the same cycle, ovf SHALL be 1 after that edge.
REQ-022 The block SHALL write results into a 2-entry in-order output FIFO on the acceptance edge; send_val SHALL rise the cycle after acceptance (latency 1).
REQ-023 The block SHALL hold FIFO occupancy states EMPTY (0), ONE (1), FULL (2); recv_rdy = not FULL, send_val = not EMPTY.
REQ-024 Occupancy transitions: enq only +1; deq only (send_val & send_rdy) -1; enq and deq together in ONE keeps ONE; enq is impossible in FULL.
REQ-025 c0r/c0c/c1r/c1c SHALL always present the head entry; they SHALL hold stable while send_val & ~send_rdy.
REQ-026 Throughput SHALL be 1 operand set per cycle when send_rdy is held high.

Reset
REQ-027 On reset, occupancy SHALL be EMPTY, send_val 0, recv_rdy 1 in the following cycle, ovf 0, and all data outputs and FIFO entries 0.
REQ-028 Reset mid-stream SHALL discard all queued results; an operand set presented during the reset cycle SHALL not be accepted.

Structure
REQ-029 The shared fixed-point package SHALL hold the occupancy state encoding and the default n/d constants.
REQ-030 The FIFO SHALL be a sub-module fixedpt_butterfly_fifo (parameter width, depth 2, val/rdy both sides); the adders, scaling, and ovf logic SHALL live in the top.

Verification (n=32, d=16)
REQ-031 a=(0x00010000,0), p=(0x00008000,0x00004000), scale=0 -> c0=(0x00018000,0x00004000), c1=(0x00008000,0xFFFFC000), send_val one cycle after accept, ovf=0.
REQ-032 ar=0x7FFF0000, pr=0x00020000, others 0, scale=0 -> c0r=0x80010000, ovf=1 and stays 1 until clr_ovf pulse.
REQ-033 scale=1, ar=pr=0x00010000, ac=0x00000003, pc=0 -> c0r=0x00010000, c1r=0, c0c=0x00000001, ovf=0.
REQ-034 send_rdy=0, recv_val high with 3 distinct sets -> 2 accepted, recv_rdy=0; then send_rdy=1 -> results emerge in order, third set accepted.
REQ-035 recv_val and send_rdy high continuously for 8 sets -> 8 results on 8 consecutive cycles, in order.
REQ-036 FIFO FULL with ovf=1, assert reset for 1 cycle -> send_val=0, recv_rdy=1, ovf=0, outputs 0; no queued result ever delivered.

Source files
------------

// File: rtl/fixedpt_butterfly_pkg.sv
// ============================================================================
// fixedpt_butterfly_pkg : shared fixed-point constants and FIFO occupancy code
// Rev 1.0
// ============================================================================
`default_nettype none

package fixedpt_butterfly_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_D = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

`default_nettype wire

// File: rtl/fixedpt_butterfly_fifo.sv
// ============================================================================
// fixedpt_butterfly_fifo : 2-entry in-order FIFO, val/rdy on both sides
// Rev 1.0
// ============================================================================
`default_nettype none

module fixedpt_butterfly_fifo
  import fixedpt_butterfly_pkg::*;
#(
  parameter int width = 4 * DEF_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enq_val,
  output logic             o_enq_rdy,
  input  logic [width-1:0] i_enq_data,
  output logic             o_deq_val,
  input  logic             i_deq_rdy,
  output logic [width-1:0] o_deq_data
);

  occ_e             r_state;
  occ_e             w_state_nxt;
  logic [width-1:0] r_head;
  logic [width-1:0] r_tail;
  logic             w_enq;
  logic             w_deq;
  logic             w_load_head;
  logic             w_load_tail;
  logic             w_shift;

  assign o_enq_rdy  = (r_state != OCC_FULL);
  assign o_deq_val  = (r_state != OCC_EMPTY);
  assign o_deq_data = r_head;
  assign w_enq      = i_enq_val & o_enq_rdy;
  assign w_deq      = i_deq_rdy & o_deq_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Head always holds the oldest entry; tail is used only when FULL.
  always_comb begin
    w_state_nxt = r_state;
    w_load_head = 1'b0;
    w_load_tail = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_enq) begin
          w_state_nxt = OCC_ONE;
          w_load_head = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_enq && w_deq) begin
          w_load_head = 1'b1;
        end else if (w_enq) begin
          w_state_nxt = OCC_FULL;
          w_load_tail = 1'b1;
        end else if (w_deq) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (w_deq) begin
          w_state_nxt = OCC_ONE;
          w_shift     = 1'b1;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_load_head) begin
        r_head <= i_enq_data;
      end else if (w_shift) begin
        r_head <= r_tail;
      end
      if (w_load_tail) begin
        r_tail <= i_enq_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixedpt_butterfly.sv
// ============================================================================
// fixedpt_butterfly : radix-2 fixed-point butterfly (a+p, a-p) with output FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module fixedpt_butterfly
  import fixedpt_butterfly_pkg::*;
#(
  parameter int n     = DEF_N,
  parameter int d     = DEF_D,
  parameter bit scale = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] pr,
  input  logic [n-1:0] pc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c0r,
  output logic [n-1:0] c0c,
  output logic [n-1:0] c1r,
  output logic [n-1:0] c1c,
  input  logic         clr_ovf,
  output logic         ovf
);

  localparam int W = 4 * n;

  if (n < 2 || d < 0 || d >= n) begin : g_param_check
    $error("fixedpt_butterfly: invalid n/d combination");
  end

  logic [n:0]   w_s0r;
  logic [n:0]   w_s0c;
  logic [n:0]   w_s1r;
  logic [n:0]   w_s1c;
  logic [n-1:0] w_c0r;
  logic [n-1:0] w_c0c;
  logic [n-1:0] w_c1r;
  logic [n-1:0] w_c1c;
  logic         w_wrap_ovf;
  logic         w_ovf_evt;
  logic         w_accept;
  logic [W-1:0] w_enq_data;
  logic [W-1:0] w_deq_data;
  logic         r_ovf;

  assign w_s0r = {ar[n-1], ar} + {pr[n-1], pr};
  assign w_s0c = {ac[n-1], ac} + {pc[n-1], pc};
  assign w_s1r = {ar[n-1], ar} - {pr[n-1], pr};
  assign w_s1c = {ac[n-1], ac} - {pc[n-1], pc};

  // Scaled mode keeps the carry bit and drops the LSB (floor divide by 2).
  assign w_c0r = scale ? w_s0r[n:1] : w_s0r[n-1:0];
  assign w_c0c = scale ? w_s0c[n:1] : w_s0c[n-1:0];
  assign w_c1r = scale ? w_s1r[n:1] : w_s1r[n-1:0];
  assign w_c1c = scale ? w_s1c[n:1] : w_s1c[n-1:0];

  assign w_wrap_ovf = (w_s0r[n] ^ w_s0r[n-1]) | (w_s0c[n] ^ w_s0c[n-1]) |
                      (w_s1r[n] ^ w_s1r[n-1]) | (w_s1c[n] ^ w_s1c[n-1]);
  assign w_ovf_evt  = !scale && w_wrap_ovf;

  assign w_accept   = recv_val & recv_rdy;
  assign w_enq_data = {w_c0r, w_c0c, w_c1r, w_c1c};

  // A new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_ovf_evt) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;

  fixedpt_butterfly_fifo #(
    .width (W)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_enq_val  (recv_val),
    .o_enq_rdy  (recv_rdy),
    .i_enq_data (w_enq_data),
    .o_deq_val  (send_val),
    .i_deq_rdy  (send_rdy),
    .o_deq_data (w_deq_data)
  );

  assign c0r = w_deq_data[4*n-1:3*n];
  assign c0c = w_deq_data[3*n-1:2*n];
  assign c1r = w_deq_data[2*n-1:n];
  assign c1c = w_deq_data[n-1:0];

endmodule

`default_nettype wire
